// File: rtl/led_seq_pkg.sv
// led_seq_pkg -- shared defaults for the LED blink sequencer.
//   DIV_BITS_DEF : default width of the tick-period input
//   PAT_LEN_DEF  : default pattern length in bits
//   PWM_BITS_DEF : default brightness resolution
//   CLK_HZ       : HFOSC system clock frequency feeding clkin
package led_seq_pkg;

  localparam int DIV_BITS_DEF = 28;
  localparam int PAT_LEN_DEF  = 16;
  localparam int PWM_BITS_DEF = 4;
  localparam int CLK_HZ       = 48_000_000;

endpackage

// File: rtl/led_blink_seq_tick_prescaler.sv
// tick_prescaler -- programmable tick generator for the LED sequencer.
// Ports:
//   clkin  in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   enable in  count while high, hold count at 0 while low
//   div    in  tick period in clkin cycles (0 and 1 both mean every cycle)
//   tick   out combinational, high in the last cycle of each period
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] div,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;
  logic                at_end;

  always_comb begin
    // The >= compare also catches div being lowered below the running count:
    // that cycle ticks and the period restarts cleanly from 0.
    at_end = (div <= DIV_BITS'(1)) || (cnt_q >= (div - DIV_BITS'(1)));
    tick   = enable && at_end;
    cnt_d  = cnt_q + DIV_BITS'(1);
    if (!enable || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_seq.sv
// led_blink_seq -- shifts a blink pattern out to an LED, one bit per tick,
// with a one-deep pending buffer that swaps in at pattern wrap.
// Ports:
//   clkin      in  system clock (HFOSC), rising edge
//   rst_n      in  asynchronous active-low reset
//   div        in  tick period in clkin cycles
//   enable     in  run the sequencer
//   pat_data   in  new pattern, bit 0 shown first
//   pat_valid  in  pat_data offered
//   pat_ready  out pending buffer empty
//   brightness in  PWM duty level (only used with PWM compiled in)
//   led        out registered LED level to the open-drain pad driver
//   wrap       out one-cycle pulse after the tick that wraps the bit index
// Build option: define LED_BLINK_SEQ_PWM_EN to gate the LED with a
// free-running PWM counter compared against brightness.
module led_blink_seq
  import led_seq_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEF,
  parameter int PAT_LEN  = PAT_LEN_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic [DIV_BITS-1:0] div,
  input  logic                enable,
  input  logic [PAT_LEN-1:0]  pat_data,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led,
  output logic                wrap
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

  logic               tick;
  logic               at_last;
  logic               accept;
  logic               load;
  logic               pwm_on;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [PAT_LEN-1:0] active_q,    active_d;
  logic [PAT_LEN-1:0] pend_q,      pend_d;
  logic               pend_full_q, pend_full_d;
  logic               led_q,       led_d;
  logic               wrap_q,      wrap_d;

  tick_prescaler #(
    .DIV_BITS(DIV_BITS)
  ) u_prescaler (
    .clkin (clkin),
    .rst_n (rst_n),
    .enable(enable),
    .div   (div),
    .tick  (tick)
  );

`ifdef LED_BLINK_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  assign pwm_on = (pwm_cnt_q < brightness);
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  always_comb begin
    at_last = (idx_q == IDX_LAST);
    accept  = pat_valid && !pend_full_q;
    // While stopped there is no pattern on show, so a pending one is taken
    // immediately rather than waiting for a wrap that will never come.
    load    = pend_full_q && (!enable || (tick && at_last));

    idx_d = idx_q;
    if (!enable) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = at_last ? '0 : idx_q + IDX_W'(1);
    end

    active_d    = load ? pend_q : active_q;
    pend_d      = accept ? pat_data : pend_q;
    // accept and load are exclusive: accept needs the buffer empty, load full.
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (load) begin
      pend_full_d = 1'b0;
    end

    wrap_d = tick && at_last;
    led_d  = enable && active_q[idx_q] && pwm_on;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      led_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      led_q       <= led_d;
      wrap_q      <= wrap_d;
    end
  end

  assign pat_ready = !pend_full_q;
  assign led       = led_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_blink_seq.sv
// tb_led_blink_seq -- directed self-checking bench for led_blink_seq.
// With LED_BLINK_SEQ_PWM_EN defined the brightness scenarios run instead of
// the pattern/handshake/reset scenarios.
module tb_led_blink_seq;

  localparam int DIV_BITS = 28;
  localparam int PAT_LEN  = 16;
  localparam int PWM_BITS = 4;

  logic                clkin;
  logic                rst_n;
  logic [DIV_BITS-1:0] div;
  logic                enable;
  logic [PAT_LEN-1:0]  pat_data;
  logic                pat_valid;
  logic                pat_ready;
  logic [PWM_BITS-1:0] brightness;
  logic                led;
  logic                wrap;

  int n_chk  = 0;
  int n_fail = 0;

  led_blink_seq #(
    .DIV_BITS(DIV_BITS),
    .PAT_LEN (PAT_LEN),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .div       (div),
    .enable    (enable),
    .pat_data  (pat_data),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .brightness(brightness),
    .led       (led),
    .wrap      (wrap)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  function automatic logic bitof(input logic [15:0] p, input int i);
    return p[i % 16];
  endfunction

  // Index after edge j in the div 100 -> 3 scenario (div lowered after edge 50).
  function automatic int idx_c(input int j);
    return (j < 51) ? 0 : 1 + (j - 51) / 3;
  endfunction

  // Offer a pattern while enable is low: accepted on one edge, made active on the next.
  task automatic load_idle(input logic [15:0] p);
    pat_data  = p;
    pat_valid = 1'b1;
    step(1);
    check("ld_ready_low", pat_ready, 1'b0);
    pat_valid = 1'b0;
    step(1);
    check("ld_ready_high", pat_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] pexp;
    int          highs;

    rst_n      = 1'b0;
    enable     = 1'b0;
    div        = '0;
    pat_data   = '0;
    pat_valid  = 1'b0;
    brightness = '0;
    step(2);
    check("rst_led",   led,       1'b0);
    check("rst_wrap",  wrap,      1'b0);
    check("rst_ready", pat_ready, 1'b1);
    rst_n = 1'b1;
    step(1);

`ifndef LED_BLINK_SEQ_PWM_EN
    // div=4, pattern 0005: each bit held 4 cycles, wrap every 64 cycles.
    div = DIV_BITS'(4);
    load_idle(16'h0005);
    enable = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      step(1);
      check("a_led",  led,  bitof(16'h0005, (k - 1) / 4));
      check("a_wrap", wrap, (k % 64) == 0);
    end

    // div=1 then div=0: one bit per cycle; 00FF pends until wrap, FF00 waits behind it.
    enable = 1'b0;
    step(2);
    div       = DIV_BITS'(1);
    pat_data  = 16'h00FF;
    pat_valid = 1'b1;
    enable    = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      pexp = (k <= 16) ? 16'h0005 : (k <= 32) ? 16'h00FF : 16'hFF00;
      check("b_led",   led,       bitof(pexp, k - 1));
      check("b_wrap",  wrap,      (k % 16) == 0);
      check("b_ready", pat_ready, (k == 16) || (k >= 32));
      if (k == 1)  pat_data  = 16'hFF00;
      if (k == 17) pat_valid = 1'b0;
      if (k == 48) div       = '0;
    end

    // div lowered from 100 to 3 with the count at 50: tick that cycle, then every 3.
    enable = 1'b0;
    step(2);
    load_idle(16'h5555);
    div    = DIV_BITS'(100);
    enable = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      step(1);
      check("c_led", led, bitof(16'h5555, idx_c(k - 1)));
      if (k == 50) div = DIV_BITS'(3);
    end

    // Asynchronous reset at idx 7 with a pattern pending.
    enable = 1'b0;
    step(2);
    load_idle(16'hFFFF);
    div       = '0;
    pat_data  = 16'hAAAA;
    pat_valid = 1'b1;
    enable    = 1'b1;
    step(1);
    pat_valid = 1'b0;
    step(6);
    check("d_led_pre",   led,       1'b1);
    check("d_ready_pre", pat_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("d_led_async",   led,       1'b0);
    check("d_ready_async", pat_ready, 1'b1);
    check("d_wrap_async",  wrap,      1'b0);
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("d_led",   led,       1'b0);
      check("d_wrap",  wrap,      k == 16);
      check("d_ready", pat_ready, 1'b1);
    end
`else
    // PWM gating over an all-ones pattern: count high cycles across two PWM periods.
    div = '0;
    load_idle(16'hFFFF);
    brightness = PWM_BITS'(4);
    enable     = 1'b1;
    step(1);
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (led) highs++;
    end
    check("p_duty4", highs, 8);

    brightness = '0;
    step(2);
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (led) highs++;
    end
    check("p_duty0", highs, 0);

    brightness = PWM_BITS'(15);
    step(2);
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (led) highs++;
    end
    check("p_duty15", highs, 30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
